// File: rtl/led_mode_ctrl_pkg.sv
// led_mode_ctrl_pkg: mode codes, debounce FSM states and modulo-3 step helpers
// shared by the key debouncer and the mode controller.
package led_mode_ctrl_pkg;

    localparam logic [1:0] MODE_RUN     = 2'd0;
    localparam logic [1:0] MODE_BLINK   = 2'd1;
    localparam logic [1:0] MODE_RUN_INV = 2'd2;
    localparam int         MODE_NUM     = 3;

    typedef enum logic [1:0] {
        DB_IDLE,
        DB_PRESS_WAIT,
        DB_HELD,
        DB_REL_WAIT
    } deb_state_e;

    // Any code at or above the last legal mode (including an upset 3) wraps to RUN.
    function automatic logic [1:0] mode_next(input logic [1:0] m);
        return (m >= 2'(MODE_NUM - 1)) ? MODE_RUN : m + 2'd1;
    endfunction

    function automatic logic [1:0] mode_prev(input logic [1:0] m);
        return (m == MODE_RUN) ? MODE_RUN_INV : (m > MODE_RUN_INV) ? MODE_RUN : m - 2'd1;
    endfunction

endpackage

// File: rtl/led_mode_ctrl_key_debounce.sv
// key_debounce: 2-flop synchronizer plus IDLE/PRESS_WAIT/HELD/REL_WAIT debounce FSM
// for one active-low key; emits a single-cycle press pulse and the debounced level.
module key_debounce
    import led_mode_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int CNT_W        = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press,
    output logic level
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

    logic [1:0]       sync_q;
    deb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             key_low, cnt_done;

    assign key_low  = ~sync_q[1];
    assign cnt_done = (cnt_q == CNT_MAX);
    assign level    = (state_q == DB_HELD) || (state_q == DB_REL_WAIT);

    // Sync flops preset to released so reset never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;
            state_q <= DB_IDLE;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], key_n};
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press   = 1'b0;
        case (state_q)
            DB_IDLE: begin
                if (key_low) begin
                    state_d = DB_PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            DB_PRESS_WAIT: begin
                if (!key_low) begin
                    state_d = DB_IDLE;
                end else if (cnt_done) begin
                    state_d = DB_HELD;
                    press   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DB_HELD: begin
                if (!key_low) begin
                    state_d = DB_REL_WAIT;
                    cnt_d   = '0;
                end
            end
            DB_REL_WAIT: begin
                if (key_low) begin
                    state_d = DB_HELD;
                end else if (cnt_done) begin
                    state_d = DB_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

endmodule

// File: rtl/led_mode_ctrl.sv
// led_mode_ctrl: debounces next/prev keys and steps the LED pattern select modulo 3.
// Define LED_MODE_AUTO_CYCLE_EN to auto-advance the mode after AUTO_CYCLE_CYC idle cycles.
module led_mode_ctrl
    import led_mode_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYC   = 1_000_000,
    parameter int CNT_W          = 20,
    parameter int AUTO_CYCLE_CYC = 250_000_000,
    parameter int AUTO_W         = 28
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] key_n,
    output logic [1:0] ctrl,
    output logic       mode_chg,
    output logic [1:0] key_level
);

    logic [1:0] press;
    logic [1:0] ctrl_q, ctrl_d;
    logic       mode_chg_q, mode_chg_d;
    logic       auto_step;

    for (genvar g = 0; g < 2; g++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC),
            .CNT_W       (CNT_W)
        ) u_deb (
            .clk  (clk),
            .rst_n(rst_n),
            .key_n(key_n[g]),
            .press(press[g]),
            .level(key_level[g])
        );
    end

`ifdef LED_MODE_AUTO_CYCLE_EN
    localparam logic [AUTO_W-1:0] AUTO_MAX = AUTO_W'(AUTO_CYCLE_CYC - 1);
    logic [AUTO_W-1:0] idle_q, idle_d;

    // Any key activity holds the idle counter at zero.
    always_comb begin
        auto_step = (idle_q == AUTO_MAX);
        idle_d    = ((|press) || (|key_level) || auto_step) ? '0 : idle_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) idle_q <= '0;
        else        idle_q <= idle_d;
    end
`else
    logic [AUTO_W-1:0] unused_auto;
    assign unused_auto = AUTO_W'(AUTO_CYCLE_CYC - 1);
    assign auto_step   = 1'b0;
`endif

    always_comb begin
        ctrl_d     = (&press)   ? MODE_RUN :
                     press[0]   ? mode_next(ctrl_q) :
                     press[1]   ? mode_prev(ctrl_q) :
                     auto_step  ? mode_next(ctrl_q) : ctrl_q;
        mode_chg_d = (ctrl_d != ctrl_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q     <= MODE_RUN;
            mode_chg_q <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            mode_chg_q <= mode_chg_d;
        end
    end

    assign ctrl     = ctrl_q;
    assign mode_chg = mode_chg_q;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// tb_led_mode_ctrl: directed self-checking bench for led_mode_ctrl with DEBOUNCE_CYC=8,
// AUTO_CYCLE_CYC=32; key-edge-to-ctrl latency expected to be 2 + 8 + 1 = 11 cycles.
module tb_led_mode_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] key_n = 2'b11;
    logic [1:0] ctrl;
    logic       mode_chg;
    logic [1:0] key_level;

    int n_checks = 0;
    int n_fail   = 0;

    int         lat, pulses;
    logic [1:0] lvl;

    led_mode_ctrl #(
        .DEBOUNCE_CYC  (8),
        .CNT_W         (4),
        .AUTO_CYCLE_CYC(32),
        .AUTO_W        (6)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_n    (key_n),
        .ctrl     (ctrl),
        .mode_chg (mode_chg),
        .key_level(key_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives the masked keys low for 'hold' cycles, then releases for 20 cycles.
    // lat = first cycle (1-based, after the key edge) on which ctrl differs, -1 if never.
    task automatic press_measure(input logic [1:0] mask, input int hold,
                                 output int l, output int p, output logic [1:0] kl);
        logic [1:0] c0;
        c0 = ctrl;
        l  = -1;
        p  = 0;
        key_n = ~mask;
        for (int i = 1; i <= hold; i++) begin
            @(posedge clk);
            #1;
            if (l < 0 && ctrl != c0) l = i;
            p += int'(mode_chg);
        end
        kl = key_level;
        key_n = 2'b11;
        repeat (20) begin
            @(posedge clk);
            #1;
            p += int'(mode_chg);
        end
    endtask

    initial begin
        // 1: reset, keys pressed while in reset do nothing
        key_n = 2'b00;
        tick(5);
        check("rst_ctrl", ctrl, 0);
        check("rst_chg", mode_chg, 0);
        check("rst_level", key_level, 0);
        key_n = 2'b11;
        tick(3);
        rst_n = 1'b1;
        tick(3);
        check("post_rst_ctrl", ctrl, 0);

        // 2: three next presses, wrap 2 -> 0
        press_measure(2'b01, 20, lat, pulses, lvl);
        check("next1_lat", lat, 11);
        check("next1_pulses", pulses, 1);
        check("next1_ctrl", ctrl, 1);
        check("next1_level", lvl, 1);
        check("next1_rel_level", key_level, 0);
        press_measure(2'b01, 20, lat, pulses, lvl);
        check("next2_ctrl", ctrl, 2);
        check("next2_pulses", pulses, 1);
        press_measure(2'b01, 20, lat, pulses, lvl);
        check("next3_wrap_ctrl", ctrl, 0);
        check("next3_lat", lat, 11);

        // 3: prev from 0 wraps to 2, then a bouncing key is rejected
        press_measure(2'b10, 20, lat, pulses, lvl);
        check("prev_ctrl", ctrl, 2);
        check("prev_lat", lat, 11);
        check("prev_level", lvl, 2);
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            if (i % 3 == 0) key_n[0] = ~key_n[0];
            tick(1);
            pulses += int'(mode_chg);
            if (key_level != 2'b00) pulses += 100;
        end
        key_n = 2'b11;
        tick(6);
        check("bounce_events", pulses, 0);
        check("bounce_ctrl", ctrl, 2);

        // 4: simultaneous presses force RUN, no pulse if already RUN
        press_measure(2'b11, 20, lat, pulses, lvl);
        check("both_ctrl", ctrl, 0);
        check("both_pulses", pulses, 1);
        check("both_level", lvl, 3);
        press_measure(2'b11, 20, lat, pulses, lvl);
        check("both0_ctrl", ctrl, 0);
        check("both0_pulses", pulses, 0);
        check("both0_lat", lat, -1);

        // 5: long hold gives a single step; reset mid PRESS_WAIT discards the press
        press_measure(2'b01, 100, lat, pulses, lvl);
        check("hold_ctrl", ctrl, 1);
        check("hold_pulses", pulses, 1);
        key_n = 2'b10;
        tick(7);
        rst_n = 1'b0;
        tick(2);
        check("midrst_ctrl", ctrl, 0);
        check("midrst_level", key_level, 0);
        rst_n = 1'b1;
        lat = -1;
        pulses = 0;
        for (int i = 1; i <= 30; i++) begin
            tick(1);
            if (lat < 0 && ctrl != 2'd0) lat = i;
            pulses += int'(mode_chg);
        end
        key_n = 2'b11;
        tick(20);
        check("redeb_lat", lat, 11);
        check("redeb_ctrl", ctrl, 1);
        check("redeb_pulses", pulses, 1);

        // 6: idle behaviour
`ifdef LED_MODE_AUTO_CYCLE_EN
        pulses = 0;
        for (int i = 0; i < 40 && pulses == 0; i++) begin
            tick(1);
            pulses += int'(mode_chg);
        end
        check("auto_pulse", pulses, 1);
        check("auto_ctrl", ctrl, 2);
`else
        pulses = 0;
        for (int i = 0; i < 1000; i++) begin
            tick(1);
            pulses += int'(mode_chg);
        end
        check("idle_pulses", pulses, 0);
        check("idle_ctrl", ctrl, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
